// File: rtl/uart_rx_core.sv
// UART receiver: oversampled start/data/parity/stop framing with parity and stop error pulses.
// Define UART_RX_MAJORITY_EN to vote 2-of-3 samples around mid-bit instead of a single sample.
module uart_rx_core #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [WIDTH-1:0]      P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);
    localparam int BW = $clog2(WIDTH + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int SN = 3;
`else
    localparam int SN = 1;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   edge_q, edge_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [WIDTH-1:0]        shift_q, shift_d;
    logic [SN-1:0]           samp_q, samp_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic [PRESCALE_W-1:0]   pre_q, pre_d;
    logic                    mism_q, mism_d;
    logic [WIDTH-1:0]        pdata_q, pdata_d;
    logic                    dv_q, dv_d;
    logic                    pe_q, pe_d;
    logic                    se_q, se_d;

    logic [PRESCALE_W-1:0]   half, last;
    logic                    bit_val;

    assign half = pre_q >> 1;
    assign last = pre_q - PRESCALE_W'(1);

`ifdef UART_RX_MAJORITY_EN
    assign bit_val = (samp_q[2] & samp_q[1]) | (samp_q[2] & samp_q[0]) | (samp_q[1] & samp_q[0]);
`else
    assign bit_val = samp_q[0];
`endif

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        samp_d    = samp_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        pre_d     = pre_q;
        mism_d    = mism_q;
        pdata_d   = pdata_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        se_d      = 1'b0;

        // Sample window is evaluated for every non-idle bit, including start and stop.
`ifdef UART_RX_MAJORITY_EN
        if (state_q != IDLE && (edge_q == half - PRESCALE_W'(1) || edge_q == half ||
                                edge_q == half + PRESCALE_W'(1)))
            samp_d = {samp_q[1:0], RX_IN};
`else
        if (state_q != IDLE && edge_q == half)
            samp_d = RX_IN;
`endif

        case (state_q)
            IDLE: begin
                edge_d = '0;
                if (!RX_IN) begin
                    state_d   = START;
                    edge_d    = PRESCALE_W'(1);
                    bit_d     = '0;
                    mism_d    = 1'b0;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    pre_d     = Prescale;
                end
            end
            START: begin
                if (edge_q == last) begin
                    edge_d  = '0;
                    bit_d   = '0;
                    state_d = bit_val ? IDLE : DATA;
                end else begin
                    edge_d = edge_q + PRESCALE_W'(1);
                end
            end
            DATA: begin
                if (edge_q == last) begin
                    edge_d  = '0;
                    shift_d = {bit_val, shift_q[WIDTH-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BW'(WIDTH - 1))
                        state_d = par_en_q ? PARITY : STOP;
                end else begin
                    edge_d = edge_q + PRESCALE_W'(1);
                end
            end
            PARITY: begin
                if (edge_q == last) begin
                    edge_d  = '0;
                    mism_d  = bit_val != ((^shift_q) ^ par_typ_q);
                    state_d = STOP;
                end else begin
                    edge_d = edge_q + PRESCALE_W'(1);
                end
            end
            STOP: begin
                // Decide early so the line is back in IDLE before a back-to-back start edge.
                if (edge_q == half + PRESCALE_W'(2)) begin
                    se_d    = !bit_val;
                    pe_d    = par_en_q & mism_q;
                    dv_d    = bit_val & !(par_en_q & mism_q);
                    if (dv_d)
                        pdata_d = shift_q;
                    edge_d  = '0;
                    state_d = IDLE;
                end else begin
                    edge_d = edge_q + PRESCALE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                edge_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            samp_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            pre_q     <= '0;
            mism_q    <= 1'b0;
            pdata_q   <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            samp_q    <= samp_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            pre_q     <= pre_d;
            mism_q    <= mism_d;
            pdata_q   <= pdata_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            se_q      <= se_d;
        end
    end

    assign P_DATA     = pdata_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboarded bench for uart_rx_core: directed frames push expected pulses, a monitor pops and checks.
module tb_uart_rx_core;
    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx_core #(.WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .Prescale(Prescale), .P_DATA(P_DATA), .data_valid(data_valid),
        .par_err(par_err), .stp_err(stp_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] kind;   // {data_valid, par_err, stp_err}
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_miss = 0;
    logic [7:0] exp_pdata = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (data_valid || par_err || stp_err) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {29'd0, data_valid, par_err, stp_err}, 0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind", {29'd0, data_valid, par_err, stp_err}, {29'd0, e.kind});
                    check("p_data", {24'd0, P_DATA}, {24'd0, e.data});
                    check("latency_cyc", cyc, e.cyc);
                end
            end
        end
    end

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Drives one frame starting on a negedge. gbit/gcyc invert one cycle of frame bit gbit.
    // mess perturbs the config inputs after the start bit to prove they were latched.
    task automatic send_frame(input logic [7:0] d, input int pre, input logic pen, input logic ptyp,
                              input logic pflip, input logic stop, input int gbit, input int gcyc,
                              input logic mess, input logic [7:0] exp_d);
        logic [10:0] bits;
        int          n;
        logic        pe, se, dv;
        exp_t        e;
        n = pen ? 11 : 10;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (pen) begin
            bits[9]  = (^d) ^ ptyp ^ pflip;
            bits[10] = stop;
        end else begin
            bits[9] = stop;
        end
        pe = pen & pflip;
        se = !stop;
        dv = !pe && !se;
        Prescale = 6'(pre);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        for (int b = 0; b < n; b++) begin
            if (b == n - 1) begin
                if (dv) exp_pdata = exp_d;
                e.kind = {dv, pe, se};
                e.data = exp_pdata;
                e.cyc  = cyc + pre / 2 + 3;
                sb.push_back(e);
            end
            for (int j = 0; j < pre; j++) begin
                RX_IN = bits[b] ^ (b == gbit && j == gcyc);
                if (mess && b == 1 && j == 0) begin
                    Prescale = (pre == 16) ? 6'd8 : 6'd16;
                    PAR_EN   = !pen;
                    PAR_TYP  = !ptyp;
                end
                @(negedge CLK);
            end
        end
        RX_IN = 1'b1;
    endtask

    initial begin
        logic [7:0] ab;
        RST = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_data_valid", data_valid, 0);
        check("rst_par_err", par_err, 0);
        check("rst_stp_err", stp_err, 0);
        check("rst_p_data", P_DATA, 0);
        RST = 1'b0;
        idle(4);

        // Good frame with even parity, then a parity error that must hold P_DATA.
        send_frame(8'hA5, 8, 1, 0, 0, 1, -1, 0, 0, 8'hA5);  idle(16);
        send_frame(8'h3C, 16, 1, 0, 1, 1, -1, 0, 0, 8'h3C); idle(32);
        // Stop error, then a good frame while config inputs wander mid-frame.
        send_frame(8'h81, 8, 0, 0, 0, 0, -1, 0, 0, 8'h81);  idle(16);
        send_frame(8'h42, 8, 0, 0, 0, 1, -1, 0, 1, 8'h42);  idle(16);
        // Odd parity, correct bit.
        send_frame(8'h37, 16, 1, 1, 0, 1, -1, 0, 0, 8'h37); idle(32);
        // Back-to-back at Prescale 32.
        send_frame(8'h00, 32, 0, 0, 0, 1, -1, 0, 0, 8'h00);
        send_frame(8'hFF, 32, 0, 0, 0, 1, -1, 0, 0, 8'hFF); idle(64);

        // Short start glitch: no pulse expected.
        Prescale = 6'd8; PAR_EN = 1'b0;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        idle(16);

        // Reset in the middle of data bit 3.
        ab = 8'hC3;
        RX_IN = 1'b0; repeat (8) @(negedge CLK);
        for (int i = 0; i < 3; i++) begin RX_IN = ab[i]; repeat (8) @(negedge CLK); end
        RX_IN = ab[3]; repeat (3) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("midrst_data_valid", data_valid, 0);
        check("midrst_par_err", par_err, 0);
        check("midrst_stp_err", stp_err, 0);
        check("midrst_p_data", P_DATA, 0);
        exp_pdata = 8'h00;
        @(negedge CLK);
        RST = 1'b0;
        idle(16);
        send_frame(8'h5A, 8, 0, 0, 0, 1, -1, 0, 0, 8'h5A); idle(16);

        // One-cycle glitch at edge 8 of data bit 0.
`ifdef UART_RX_MAJORITY_EN
        send_frame(8'hF0, 16, 0, 0, 0, 1, 1, 8, 0, 8'hF0);
`else
        send_frame(8'hF0, 16, 0, 0, 0, 1, 1, 8, 0, 8'hF1);
`endif
        idle(40);

        check("outstanding_expectations", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
